// File: rtl/rv_mdu_iter_if.sv
// Handshake and operand/result bundle between the multicycle control unit and
// the iterative multiply/divide unit.
interface rv_mdu_iter_if #(parameter int Width = 32);
  logic             start;
  logic [2:0]       f3;
  logic [Width-1:0] a;
  logic [Width-1:0] b;
  logic             kill;
  logic             busy;
  logic             done;
  logic [Width-1:0] result;

  modport master (output start, f3, a, b, kill, input busy, done, result);
  modport slave  (input start, f3, a, b, kill, output busy, done, result);
endinterface

// File: rtl/rv_mdu_iter.sv
// Iterative RV32M/RV64M multiply/divide: radix-2 shift-add multiply, restoring
// divide on operand magnitudes, sign fix-up and RISC-V special cases in FIX.
//
// state | meaning
// IDLE  | waiting for start; result held
// MUL   | shift-add iterations (one cycle with FastMul)
// DIV   | restoring divide, one quotient bit per cycle
// FIX   | sign correction, result write, done pulse
module rv_mdu_iter #(
  parameter int Width    = 32,
  parameter int FastMul  = 0,
  parameter int EarlyOut = 1
) (
  input  logic         clk,
  input  logic         rst,
  rv_mdu_iter_if.slave bus
);
  localparam int CW = $clog2(Width + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [2:0]         f3_q, f3_d;
  logic [Width-1:0]   a_q, a_d;
  logic               sa_q, sa_d, neg_q, neg_d, bz_q, bz_d, ovf_q, ovf_d;
  logic [2*Width-1:0] mcand_q, mcand_d, prod_q, prod_d;
  logic [Width-1:0]   mplier_q, mplier_d, q_q, q_d;
  logic [Width:0]     rem_q, rem_d, dvs_q, dvs_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [Width-1:0]   result_q, result_d;

  logic               sgn_a, sgn_b, bz, ovf, spc, ge;
  logic [Width:0]     mag_a, mag_b;
  logic [Width+1:0]   shifted;
  logic [2*Width-1:0] prod_s;
  logic [Width-1:0]   quo_s, rem_s, fix_res;

  always_comb begin
    sgn_a = bus.a[Width-1] & (bus.f3 inside {3'd1, 3'd2, 3'd4, 3'd6});
    sgn_b = bus.b[Width-1] & (bus.f3 inside {3'd1, 3'd4, 3'd6});
    mag_a = sgn_a ? -{1'b1, bus.a} : {1'b0, bus.a};
    mag_b = sgn_b ? -{1'b1, bus.b} : {1'b0, bus.b};
    bz    = (bus.b == '0);
    ovf   = ~bus.f3[0] & (bus.a == {1'b1, {(Width-1){1'b0}}}) & (&bus.b);
    spc   = bus.f3[2] & (bz | ovf) & (EarlyOut != 0);

    shifted = {rem_q, q_q[Width-1]};
    ge      = (shifted >= {1'b0, dvs_q});

    prod_s = neg_q ? -prod_q : prod_q;
    quo_s  = neg_q ? -q_q : q_q;
    rem_s  = sa_q ? -rem_q[Width-1:0] : rem_q[Width-1:0];
    fix_res = '0;
    if (!f3_q[2])  fix_res = (f3_q[1:0] == 2'd0) ? prod_s[Width-1:0] : prod_s[2*Width-1:Width];
    else if (bz_q) fix_res = f3_q[1] ? a_q : '1;
    else if (ovf_q) fix_res = f3_q[1] ? '0 : a_q;
    else           fix_res = f3_q[1] ? rem_s : quo_s;
  end

  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    a_d      = a_q;
    sa_d     = sa_q;
    neg_d    = neg_q;
    bz_d     = bz_q;
    ovf_d    = ovf_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    q_d      = q_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    result_d = result_q;
    if (bus.kill) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (bus.start) begin
          f3_d     = bus.f3;
          a_d      = bus.a;
          sa_d     = sgn_a;
          neg_d    = sgn_a ^ sgn_b;
          bz_d     = bus.f3[2] & bz;
          ovf_d    = bus.f3[2] & ovf;
          mcand_d  = {{(Width-1){1'b0}}, mag_a};
          mplier_d = mag_b[Width-1:0];
          prod_d   = '0;
          q_d      = mag_a[Width-1:0];
          rem_d    = '0;
          dvs_d    = mag_b;
          cnt_d    = (FastMul != 0 && !bus.f3[2]) ? '0 : CW'(Width - 1);
          state_d  = spc ? S_FIX : (bus.f3[2] ? S_DIV : S_MUL);
        end
        S_MUL: begin
          if (FastMul != 0)
            prod_d = {{Width{1'b0}}, mcand_q[Width-1:0]} * {{Width{1'b0}}, mplier_q};
          else if (mplier_q[0])
            prod_d = prod_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CW'(1);
          if (cnt_q == '0) state_d = S_FIX;
        end
        S_DIV: begin
          rem_d = ge ? shifted[Width:0] - dvs_q : shifted[Width:0];
          q_d   = {q_q[Width-2:0], ge};
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) state_d = S_FIX;
        end
        default: begin
          result_d = fix_res;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      f3_q     <= '0;
      a_q      <= '0;
      sa_q     <= 1'b0;
      neg_q    <= 1'b0;
      bz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      q_q      <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      a_q      <= a_d;
      sa_q     <= sa_d;
      neg_q    <= neg_d;
      bz_q     <= bz_d;
      ovf_q    <= ovf_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      q_q      <= q_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_rv_mdu_iter.sv
// Scoreboard bench: two units (iterative/early-out and fast-multiply/no-early-out)
// share operands; each issue pushes a model result and latency, a monitor pops on done.
module tb_rv_mdu_iter;
  localparam int W = 32;
  localparam logic [31:0] MIN = 32'h8000_0000;

  typedef struct {
    logic [31:0] exp;
    int          acc;
    int          lat;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  logic st_s, st_f, drv_kill;
  logic [2:0]  drv_f3;
  logic [31:0] drv_a, drv_b;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  ent_t q_s[$];
  ent_t q_f[$];
  logic [31:0] last_s, last_f;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rv_mdu_iter_if #(.Width(W)) if_s();
  rv_mdu_iter_if #(.Width(W)) if_f();

  assign if_s.start = st_s;
  assign if_s.f3    = drv_f3;
  assign if_s.a     = drv_a;
  assign if_s.b     = drv_b;
  assign if_s.kill  = drv_kill;
  assign if_f.start = st_f;
  assign if_f.f3    = drv_f3;
  assign if_f.a     = drv_a;
  assign if_f.b     = drv_b;
  assign if_f.kill  = drv_kill;

  rv_mdu_iter #(.Width(W), .FastMul(0), .EarlyOut(1)) u_slow (.clk(clk), .rst(rst), .bus(if_s));
  rv_mdu_iter #(.Width(W), .FastMul(1), .EarlyOut(0)) u_fast (.clk(clk), .rst(rst), .bus(if_f));

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    p  = '0;
    case (f)
      3'd0: p = sa * sb;
      3'd1: p = sa * sb;
      3'd2: p = sa * ub;
      3'd3: p = {32'b0, a} * {32'b0, b};
      3'd4: if (b == 0) p = '1; else if (a == MIN && b == '1) p = {32'b0, a}; else p = sa / sb;
      3'd5: if (b == 0) p = '1; else p = {32'b0, a / b};
      3'd6: if (b == 0) p = {32'b0, a}; else if (a == MIN && b == '1) p = '0; else p = sa % sb;
      default: if (b == 0) p = {32'b0, a}; else p = {32'b0, a % b};
    endcase
    if (f inside {3'd1, 3'd2, 3'd3}) return p[63:32];
    return p[31:0];
  endfunction

  function automatic int exp_lat(input int sel, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bit special;
    special = f[2] && (b == 0 || (!f[0] && a == MIN && b == '1));
    if (sel == 0) return (special) ? 1 : W + 1;
    return (f[2]) ? W + 1 : 2;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return MIN;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic on_done(input int sel, input logic [31:0] res, input logic bsy);
    ent_t e;
    if ((sel == 0 && q_s.size() == 0) || (sel == 1 && q_f.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done unit%0d: got done=1 expected no op in flight", sel);
    end else begin
      if (sel == 0) begin e = q_s.pop_front(); last_s = e.exp; end
      else          begin e = q_f.pop_front(); last_f = e.exp; end
      chk($sformatf("result unit%0d", sel), res, e.exp);
      chk($sformatf("latency unit%0d", sel), 32'(cyc - e.acc), 32'(e.lat));
      chk($sformatf("busy_at_done unit%0d", sel), {31'b0, bsy}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && if_s.done) on_done(0, if_s.result, if_s.busy);
    if (!rst && if_f.done) on_done(1, if_f.result, if_f.busy);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int sel);
    int n;
    n = 0;
    while (((sel == 0) ? if_s.busy : if_f.busy) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout unit%0d: got busy after %0d cycles expected idle", sel, n);
    end
  endtask

  task automatic issue(input int sel, input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv);
    ent_t e;
    wait_idle(sel);
    drv_f3 = f;
    drv_a  = av;
    drv_b  = bv;
    if (sel == 0) st_s = 1'b1; else st_f = 1'b1;
    step();
    st_s = 1'b0;
    st_f = 1'b0;
    e.exp = ref_op(f, av, bv);
    e.acc = cyc;
    e.lat = exp_lat(sel, f, av, bv);
    if (sel == 0) q_s.push_back(e); else q_f.push_back(e);
  endtask

  logic [2:0]  dir_f[14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                              3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
  logic [31:0] dir_a[14] = '{32'd7, MIN, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'd100, 32'd100, 32'h1234, 32'h1234, MIN, MIN, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
  logic [31:0] dir_b[14] = '{32'hFFFF_FFFD, MIN, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};

  initial begin
    int hb, t0, n;
    rst = 1'b1; st_s = 1'b0; st_f = 1'b0; drv_kill = 1'b0;
    drv_f3 = '0; drv_a = '0; drv_b = '0; last_s = '0; last_f = '0;
    repeat (3) step();
    chk("reset busy", {31'b0, if_s.busy}, 32'd0);
    chk("reset done", {31'b0, if_s.done}, 32'd0);
    chk("reset result", if_s.result, 32'd0);
    chk("reset busy fast", {31'b0, if_f.busy}, 32'd0);
    chk("reset result fast", if_f.result, 32'd0);
    rst = 1'b0;
    step();

    // MUL 7 * -3 with busy held for the whole iteration
    issue(0, 3'd0, 32'd7, 32'hFFFF_FFFD);
    hb = 0;
    for (int i = 0; i < W; i++) begin
      step();
      if (if_s.busy) hb++;
    end
    chk("busy_throughout", 32'(hb), 32'(W));

    for (int sel = 0; sel < 2; sel++)
      for (int i = 0; i < 14; i++) issue(sel, dir_f[i], dir_a[i], dir_b[i]);

    // start while busy must not resample operands
    issue(0, 3'd5, 32'd1000, 32'd9);
    repeat (3) step();
    drv_a = 32'd5; drv_b = 32'd1; drv_f3 = 3'd0; st_s = 1'b1;
    step();
    st_s = 1'b0;

    // kill at iteration 10, then immediate restart
    issue(0, 3'd4, 32'd12345, 32'hFFFF_FFEF);
    repeat (10) step();
    drv_kill = 1'b1;
    step();
    drv_kill = 1'b0;
    chk("kill busy", {31'b0, if_s.busy}, 32'd0);
    chk("kill done", {31'b0, if_s.done}, 32'd0);
    chk("kill result held", if_s.result, last_s);
    void'(q_s.pop_back());
    issue(0, 3'd7, 32'd99, 32'd10);
    chk("restart after kill", {31'b0, if_s.busy}, 32'd1);

    // kill and start together in IDLE: nothing accepted
    wait_idle(0);
    drv_kill = 1'b1; st_s = 1'b1; drv_f3 = 3'd0;
    step();
    drv_kill = 1'b0; st_s = 1'b0;
    chk("kill_vs_start busy", {31'b0, if_s.busy}, 32'd0);

    // FastMul single-cycle multiply, then back-to-back accept in the done cycle
    wait_idle(1);
    issue(1, 3'd0, 32'h0000_FFFF, 32'h0000_FFFF);
    t0 = cyc;
    issue(1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("b2b accept edge", 32'(cyc - t0), 32'd3);
    chk("b2b busy", {31'b0, if_f.busy}, 32'd1);

    for (int i = 0; i < 40; i++)
      issue($urandom_range(0, 1), 3'($urandom_range(0, 7)), pick(), pick());

    // synchronous reset mid-operation
    wait_idle(0);
    wait_idle(1);
    repeat (2) step();
    issue(0, 3'd1, $urandom, $urandom);
    repeat (5) step();
    rst = 1'b1;
    step();
    chk("rst busy", {31'b0, if_s.busy}, 32'd0);
    chk("rst done", {31'b0, if_s.done}, 32'd0);
    chk("rst result", if_s.result, 32'd0);
    rst = 1'b0;
    q_s.delete();
    q_f.delete();
    last_s = '0;
    last_f = '0;
    issue(0, 3'd6, 32'hFFFF_FFF9, 32'd2);

    n = 0;
    while ((q_s.size() != 0 || q_f.size() != 0) && n < 200) begin
      step();
      n++;
    end
    chk("drain", 32'(q_s.size() + q_f.size()), 32'd0);
    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
